weight_loader: RTL and testbench
================================

# weight_loader

Write-side counterpart of the forward-propagation `weight` streamer. It accepts a host stream of 32-bit weight words over a valid/ready handshake and assembles them into full rows. It writes each completed row into the weight store in the same row shape the streamer reads back:
- layer 0: 784 rows × 128 words
- layer 1: 128 rows × 10 words

It sits between the host/DMA ingress and the weight memory.

## Interface
Parameters:
- `DATA_W`, 32, width of one weight word
- `L0_ROWS`, 784, layer-0 row count
- `L0_COLS`, 128, layer-0 words per row
- `L1_ROWS`, 128, layer-1 row count
- `L1_COLS`, 10, layer-1 words per row

Ports:
- `clka`  in  1  sole clock; all logic on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle load request; sampled only in IDLE
- `layer`  in  1  target layer, sampled with `start` (0 = layer 0, 1 = layer 1)
- `in_data`  in  DATA_W  weight word, row-major, column 0 first
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  loader accepts a word this cycle
- `wr_en`  out  1  one-cycle row write strobe
- `wr_layer`  out  1  layer of the current write
- `wr_addr`  out  10  row index
- `wr_data`  out  L0_COLS×DATA_W  packed row, `[L0_COLS-1:0][DATA_W-1:0]`; column c in `wr_data[c]`
- `busy`  out  1  load in progress
- `done`  out  1  one-cycle pulse at load completion
- `err`  out  1  checksum mismatch flag (tied 0 without the macro)

## Operation
- States: IDLE, LOAD, CHECK (CHECK exists only with the macro).
- IDLE:
  - On `start`, latch `layer` into `wr_layer`, clear row/column counters, clear `err`, go to LOAD.
  - `in_ready` = 0.
- LOAD:
  - `in_ready` = 1 unconditionally; a word is accepted when `in_valid` is high.
  - Each accepted word goes into the row buffer at the column counter, and the column counter increments.
  - When the column counter reaches cols−1 and a word is accepted:
    - Register the full row, including that word, into `wr_data`. Layer-1 columns 10..127 are forced to 0.
    - Drive `wr_addr` with the current row and assert `wr_en` for one cycle.
    - Clear the column counter and increment the row counter.
  - Last word of the last row: go to IDLE (or CHECK with the macro).
- The row buffer is separate from the `wr_data` register, so column 0 of the next row can be accepted in the same cycle `wr_en` is high. No bubble is required between rows.
- `start` while `busy` is ignored.
- `in_valid` while not `in_ready` is ignored and the word is not consumed.
- Reset, including mid-load:
  - All state returns to IDLE; counters and row buffer are cleared.
  - All outputs return to 0, including `wr_data`, `wr_layer`, `wr_addr` and `err`.
  - A partially written store is left as is; the next load rewrites from row 0.

## Timing
- Cycle N: `start` = 1 in IDLE. Cycle N+1: `busy` = 1, `in_ready` = 1.
- Word accepted at cycle K as the last of a row → `wr_en` = 1 at cycle K+1, with `wr_addr`/`wr_data` valid that cycle only.
- Completion without the macro:
  - Final word accepted at cycle K → at K+1: `wr_en` = 1, `done` = 1, `busy` = 0, `in_ready` = 0.
  - A new `start` is honoured from K+1.
- Full-rate load time, `start` to `done`: layer 0 is 100352 + 2 cycles; layer 1 is 1280 + 2 cycles.
- Row counter is 10 bits; it never exceeds rows−1 and does not wrap within a load.

## Configuration
- `WEIGHT_LOADER_CHECKSUM_EN` defined:
  - A running sum, modulo 2^32, of all accepted data words is kept.
  - After the last data word the FSM enters CHECK with `in_ready` = 1 and accepts exactly one extra word, the checksum.
  - The cycle after that word is accepted, `done` = 1 and `busy` = 0.
  - `err` = 1 if the checksum word ≠ sum, and stays set until the next accepted `start` or reset.
- Not defined:
  - No CHECK state and no extra word.
  - `err` is constant 0.

## Structure
- Shared package `nn_pkg`:
  - `DATA_W`, layer row/column constants
  - `weight_row_t` (`logic [L0_COLS-1:0][DATA_W-1:0]`)
  - layer-select enum
  - These are also used by `weight` and the MAC array.
- One sub-module, `row_packer`: column counter, row buffer, and the registered row output with `row_valid`. The top holds the FSM, row counter and checksum.

## Test plan
- Reset: hold `rst_n` = 0 with `start`/`in_valid` toggling → all outputs 0, `in_ready` = 0; release, idle 5 cycles → no `wr_en`.
- Layer-1 full-rate load, word = row·10 + col → 128 `wr_en` pulses, `wr_addr` 0..127 in order. At row 5: `wr_data[3]` = 53 and `wr_data[10..127]` = 0. `done` coincides with the last `wr_en`, 1282 cycles after `start`.
- Layer-1 load with `in_valid` high every other cycle → identical write sequence; `wr_en` pulses 20 cycles apart; no word lost or duplicated.
- `start` pulsed at load word 50 with `layer` = 0 → ignored: `wr_layer` stays 1 and the row count stays 128. `in_valid` high in IDLE → `in_ready` = 0, nothing consumed.
- Layer-0 load, `rst_n` dropped after row 300 is written → outputs 0 immediately. A fresh layer-0 load then writes from `wr_addr` 0 with 128 columns, value pattern col.
- With `WEIGHT_LOADER_CHECKSUM_EN`, layer-1 load of all 1s:
  - checksum 1280 → `err` = 0, `done` after checksum word;
  - checksum 1281 → `err` = 1, held until the next `start`.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and types for the weight path: loader, weight streamer and MAC array.
package nn_pkg;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned L0_ROWS = 784;
    localparam int unsigned L0_COLS = 128;
    localparam int unsigned L1_ROWS = 128;
    localparam int unsigned L1_COLS = 10;

    typedef logic [L0_COLS-1:0][DATA_W-1:0] weight_row_t;

    typedef enum logic {
        LAYER_0 = 1'b0,
        LAYER_1 = 1'b1
    } layer_sel_e;
endpackage

// File: rtl/row_packer.sv
// Column counter, row buffer and registered row output; columns past col_last read as zero.
module row_packer #(
    parameter int unsigned DATA_W = nn_pkg::DATA_W,
    parameter int unsigned COLS   = nn_pkg::L0_COLS,
    localparam int unsigned CW    = $clog2(COLS)
) (
    input  logic                        clka,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        accept,
    input  logic [CW-1:0]               col_last,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        row_last,
    output logic                        row_valid,
    output logic [COLS-1:0][DATA_W-1:0] row_data
);
    logic [CW-1:0]               col;
    logic [COLS-1:0][DATA_W-1:0] row_buf;
    logic [COLS-1:0][DATA_W-1:0] row_next;

    assign row_last = (col == col_last);

    // The incoming word bypasses the buffer so the full row registers in the same cycle.
    always_comb begin
        row_next = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (CW'(c) == col)
                row_next[c] = in_data;
            else if (c <= 32'(col_last))
                row_next[c] = row_buf[c];
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row_buf   <= '0;
            row_valid <= 1'b0;
            row_data  <= '0;
        end else begin
            row_valid <= 1'b0;
            if (clear) begin
                col <= '0;
            end else if (accept) begin
                row_buf[col] <= in_data;
                if (row_last) begin
                    col       <= '0;
                    row_valid <= 1'b1;
                    row_data  <= row_next;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/weight_loader.sv
// Assembles a host word stream into weight rows and writes them to the weight store.
// Optional WEIGHT_LOADER_CHECKSUM_EN adds a trailing checksum word and the err flag.
module weight_loader #(
    parameter int unsigned DATA_W  = nn_pkg::DATA_W,
    parameter int unsigned L0_ROWS = nn_pkg::L0_ROWS,
    parameter int unsigned L0_COLS = nn_pkg::L0_COLS,
    parameter int unsigned L1_ROWS = nn_pkg::L1_ROWS,
    parameter int unsigned L1_COLS = nn_pkg::L1_COLS
) (
    input  logic                           clka,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           layer,
    input  logic [DATA_W-1:0]              in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic                           wr_en,
    output logic                           wr_layer,
    output logic [9:0]                     wr_addr,
    output logic [L0_COLS-1:0][DATA_W-1:0] wr_data,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);
    import nn_pkg::*;

    localparam int unsigned CW = $clog2(L0_COLS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    localparam logic [1:0] CHECK = 2'd2;
`endif

    logic [1:0]    state;
    logic [9:0]    row_cnt;
    logic [9:0]    row_last_idx;
    logic [CW-1:0] col_last;
    logic          start_ok;
    logic          accept;
    logic          row_last;

    assign busy         = (state != IDLE);
    assign in_ready     = busy;
    assign start_ok     = (state == IDLE) && start;
    assign accept       = (state == LOAD) && in_valid;
    assign row_last_idx = (wr_layer == LAYER_1) ? 10'(L1_ROWS - 1) : 10'(L0_ROWS - 1);
    assign col_last     = (wr_layer == LAYER_1) ? CW'(L1_COLS - 1) : CW'(L0_COLS - 1);

    row_packer #(
        .DATA_W (DATA_W),
        .COLS   (L0_COLS)
    ) u_row_packer (
        .clka      (clka),
        .rst_n     (rst_n),
        .clear     (start_ok),
        .accept    (accept),
        .col_last  (col_last),
        .in_data   (in_data),
        .row_last  (row_last),
        .row_valid (wr_en),
        .row_data  (wr_data)
    );

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_layer <= 1'b0;
            row_cnt  <= '0;
            wr_addr  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        wr_layer <= layer;
                        row_cnt  <= '0;
                    end
                end
                LOAD: begin
                    if (accept && row_last) begin
                        wr_addr <= row_cnt;
                        if (row_cnt == row_last_idx) begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                            state <= CHECK;
`else
                            state <= IDLE;
                            done  <= 1'b1;
`endif
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (in_valid) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
            err <= 1'b0;
        end else if (start_ok) begin
            sum <= '0;
            err <= 1'b0;
        end else if (accept) begin
            sum <= sum + in_data;
        end else if ((state == CHECK) && in_valid) begin
            err <= (in_data != sum);
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: stimulus queues expected row writes, a monitor checks them.
`timescale 1ns/1ps
module tb_weight_loader;
    import nn_pkg::*;

    logic              clka = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              layer = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready, wr_en, wr_layer, busy, done, err;
    logic [9:0]        wr_addr;
    weight_row_t       wr_data;

    always #5 clka = ~clka;

    weight_loader #(
        .DATA_W  (DATA_W),
        .L0_ROWS (L0_ROWS),
        .L0_COLS (L0_COLS),
        .L1_ROWS (L1_ROWS),
        .L1_COLS (L1_COLS)
    ) dut (
        .clka     (clka),
        .rst_n    (rst_n),
        .start    (start),
        .layer    (layer),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_layer (wr_layer),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    typedef struct {
        logic        lyr;
        logic [9:0]  addr;
        weight_row_t data;
        logic        dn;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned start_cyc = 0;
    int unsigned wr_count = 0;
    int unsigned done_cnt = 0;
    int unsigned done_cyc = 0;
    int unsigned last_wr_cyc = 0;
    int unsigned gap_exp = 0;
    bit          have_prev = 1'b0;
    logic        exp_err = 1'b0;

    always @(posedge clka) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expected row per write strobe.
    always @(negedge clka) begin
        if (rst_n) begin
            if (wr_en) begin
                wr_count++;
                if (q.size() == 0) begin
                    check("unexpected_wr", q.size(), 1);
                end else begin
                    int bad;
                    bad = 0;
                    mon_e = q.pop_front();
                    check("wr_addr", wr_addr, mon_e.addr);
                    check("wr_layer", wr_layer, mon_e.lyr);
                    for (int c = L0_COLS - 1; c >= 0; c--)
                        if (wr_data[c] !== mon_e.data[c]) bad = c;
                    check($sformatf("wr_data[%0d]@row%0d", bad, mon_e.addr), wr_data[bad], mon_e.data[bad]);
                    check("done_with_wr", done, mon_e.dn);
                end
                if (gap_exp != 0 && have_prev)
                    check("wr_gap", cyc - last_wr_cyc, gap_exp);
                last_wr_cyc = cyc;
                have_prev   = 1'b1;
            end else if (!busy) begin
                have_prev = 1'b0;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_busy_ready", {busy, in_ready}, 2'b00);
                check("done_err", err, exp_err);
`ifndef WEIGHT_LOADER_CHECKSUM_EN
                check("done_without_wr", wr_en, 1);
`endif
            end
        end
    end

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, {in_ready, wr_en, wr_layer, busy, done, err, wr_addr}, 0);
        check({tag, "_wr_data"}, (wr_data != '0), 0);
    endtask

    task automatic do_start(input logic l);
        start     = 1'b1;
        layer     = l;
        start_cyc = cyc;
        step();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("in_ready_after_start", in_ready, 1);
    endtask

    task automatic send(input logic [31:0] d, input int gap);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b0;
        repeat (gap) step();
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clka);
            acc = in_ready;
            step();
        end
        if (!acc) check("accept_timeout", acc, 1);
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] pat_val(input int pat, input int r, input int c, input int cols);
        case (pat)
            0:       return 32'(r * cols + c);
            1:       return 32'(c);
            default: return 32'd1;
        endcase
    endfunction

    task automatic load(input logic l, input int nrows, input int pat, input int gap,
                        input int poke_at, input int tail, input logic [31:0] adj);
        int          cols, rows;
        int unsigned w0, d0;
        logic [31:0] v, sum;
        exp_t        e;
        cols    = l ? int'(L1_COLS) : int'(L0_COLS);
        rows    = l ? int'(L1_ROWS) : int'(L0_ROWS);
        sum     = '0;
        w0      = wr_count;
        d0      = done_cnt;
        gap_exp = (gap == 0) ? cols : 2 * cols;
        do_start(l);
        for (int r = 0; r < nrows; r++) begin
            e.data = '0;
            for (int c = 0; c < cols; c++) begin
                v         = pat_val(pat, r, c, cols);
                e.data[c] = v;
                sum       = sum + v;
                if (c == cols - 1) begin
                    e.lyr  = l;
                    e.addr = 10'(r);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                    e.dn = 1'b0;
`else
                    e.dn = (r == rows - 1);
`endif
                    q.push_back(e);
                end
                if (r * cols + c == poke_at) begin
                    start = 1'b1;
                    layer = ~l;
                end
                send(v, gap);
                start = 1'b0;
            end
        end
        for (int t = 0; t < tail; t++) send(32'hDEAD_0000 + 32'(t), gap);
        if (nrows == rows) begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            exp_err = (adj != 0);
            send(sum + adj, gap);
`endif
            for (int t = 0; t < 10 && done_cnt == d0; t++) step();
            check("done_count", done_cnt - d0, 1);
`ifndef WEIGHT_LOADER_CHECKSUM_EN
            if (gap == 0) check("load_cycles", done_cyc - start_cyc + 1, rows * cols + 2);
`endif
        end
        repeat (2) step();
        check("wr_count", wr_count - w0, nrows);
        gap_exp = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with inputs toggling.
        for (int i = 0; i < 6; i++) begin
            start    = i[0];
            in_valid = ~i[0];
            layer    = 1'b1;
            in_data  = 32'hA5A5_0000 + 32'(i);
            step();
            check_zero("in_reset");
        end
        start    = 1'b0;
        in_valid = 1'b0;
        layer    = 1'b0;
        rst_n    = 1'b1;
        repeat (5) step();
        check_zero("idle_after_reset");

        // Layer 1, full rate, row*10+col.
        load(1'b1, L1_ROWS, 0, 0, -1, 0, 32'd0);

        // Valid in IDLE is ignored and not consumed.
        in_valid = 1'b1;
        in_data  = 32'hBAD0_BAD0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;

        // Layer 1, valid every other cycle.
        load(1'b1, L1_ROWS, 0, 1, -1, 0, 32'd0);

        // Layer 1 with a start pulse (layer 0) at word 50.
        load(1'b1, L1_ROWS, 0, 0, 50, 0, 32'd0);

        // Layer 0, reset mid-load after row 300.
        load(1'b0, 301, 0, 0, -1, 50, 32'd0);
        rst_n = 1'b0;
        #1;
        check_zero("midload_reset");
        step();
        rst_n = 1'b1;
        step();

        // Fresh layer 0 load restarts at row 0, value = col.
        load(1'b0, 3, 1, 0, -1, 5, 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

`ifdef WEIGHT_LOADER_CHECKSUM_EN
        load(1'b1, L1_ROWS, 2, 0, -1, 0, 32'd0);
        load(1'b1, L1_ROWS, 2, 0, -1, 0, 32'd1);
        repeat (5) step();
        check("err_held", err, 1);
        do_start(1'b1);
        check("err_cleared_by_start", err, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
`endif

        check("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
